bram_stream_reader: RTL

//  Read-side master for the single-port block RAM (registered read, 1-cycle latency).
//  On a start command it reads a contiguous address range: it drives the RAM's
//  we/addr inputs and takes the RAM's dout.

---
 rtl/bram_rd_pkg.sv | 21 ++
 rtl/bram_stream_reader_if.sv | 30 +++
 rtl/bram_rd_skid.sv | 63 ++++++
 rtl/bram_stream_reader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// ============================================================================
// Module : bram_rd_pkg
// Brief  : Shared FSM state encoding and skid-buffer depth for bram_stream_reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bram_rd_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bram_stream_reader_if.sv
// ============================================================================
// Module : bram_stream_reader_if
// Brief  : RAM read port plus valid/ready output stream of the reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output ram_we, ram_addr, m_valid, m_data,
    input  ram_dout, m_ready
  );

  modport slave (
    input  ram_we, ram_addr, m_valid, m_data,
    output ram_dout, m_ready
  );
endinterface

`default_nettype wire

// File: rtl/bram_rd_skid.sv
// ============================================================================
// Module : bram_rd_skid
// Brief  : 2-entry synchronous FIFO with a registered head word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bram_rd_skid
  import bram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  push,
  input  wire logic [DATA_WIDTH-1:0] din,
  input  wire logic                  pop,
  output logic      [1:0]            count,
  output logic      [DATA_WIDTH-1:0] head,
  output logic                       not_empty
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;

  // The caller guarantees no push when full without a pop, and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= din;
          else                 r_tail <= din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'(SKID_DEPTH)) begin
            r_head <= r_tail;
            r_tail <= din;
          end else begin
            r_head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign count     = r_count;
  assign head      = r_head;
  assign not_empty = (r_count != 2'd0);

endmodule

`default_nettype wire

// File: rtl/bram_stream_reader.sv
// ============================================================================
// Module : bram_stream_reader
// Brief  : Reads a contiguous BRAM range and emits it as a valid/ready stream.
//          Optional BRAM_RD_CHECKSUM_EN adds csum, the XOR of accepted beats.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [ADDR_WIDTH-1:0] base_addr,
  input  wire logic [ADDR_WIDTH:0]   len,
  output logic                       busy,
  output logic                       done,
`ifdef BRAM_RD_CHECKSUM_EN
  output logic      [DATA_WIDTH-1:0] csum,
`endif
  bram_stream_reader_if.master       bus
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_done;

  logic [1:0]            w_count;
  logic                  w_not_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_pop;
  logic [2:0]            w_pending;
  logic                  w_issue;
  logic                  w_last_issue;

  assign w_pop        = w_not_empty & bus.m_ready;
  // Words held or in flight once this cycle's pop has left; bounds the skid FIFO.
  assign w_pending    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == RUN) && (r_issued < r_len) && (w_pending < 3'(SKID_DEPTH));
  assign w_last_issue = w_issue && ((r_issued + (ADDR_WIDTH+1)'(1)) == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr   <= base_addr;
            r_len    <= len;
            r_issued <= '0;
            r_busy   <= 1'b1;
            if (len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            r_issued <= r_issued + (ADDR_WIDTH+1)'(1);
            if (w_last_issue) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pending == 3'd0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bram_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_inflight),
    .din       (bus.ram_dout),
    .pop       (w_pop),
    .count     (w_count),
    .head      (w_head),
    .not_empty (w_not_empty)
  );

`ifdef BRAM_RD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (r_state == IDLE && start) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum ^ w_head;
    end
  end

  assign csum = r_csum;
`endif

  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = r_addr;
  assign bus.m_valid  = w_not_empty;
  assign bus.m_data   = w_head;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

`default_nettype wire
